muldiv_seq: RTL
===============

Name: muldiv_seq

Overview:
- Iterative multiply/divide sequencer that sits beside the EX-stage ALU.
- Executes MULT/MULTU/DIV/DIVU over 34 cycles and owns the HI/LO architectural registers.
- Serves MTHI/MTLO writes in a single cycle.
- Drives a stall request to the pipeline hazard logic while busy, so MFHI/MFLO and new mult/div ops wait for completion.

Parameters:
- WIDTH, 32, operand/HI/LO width.
- CNT_W, 6, iteration counter width (must hold WIDTH).

Ports:
- clk  input  1  system clock, all state on rising edge.
- rst  input  1  synchronous active-high reset.
- start  input  1  operation request from EX stage, valid for one cycle.
- op  input  3  000 MULT, 001 MULTU, 010 DIV, 011 DIVU, 100 MTHI, 101 MTLO; 110/111 no-op.
- a  input  WIDTH  rs operand (dividend / multiplicand / MTHI-MTLO data).
- b  input  WIDTH  rt operand (divisor / multiplier).
- rd_hilo  input  1  an MFHI/MFLO is in EX this cycle.
- flush  input  1  abort in-progress op (branch/exception squash).
- busy  output  1  iterative op in progress.
- stall  output  1  pipeline must hold EX and earlier stages.
- done  output  1  one-cycle pulse; new HI/LO visible this cycle.
- hi  output  WIDTH  HI register.
- lo  output  WIDTH  LO register.

Behaviour:
- Reset:
  - hi=0, lo=0, busy=0, done=0, state=IDLE, counter=0.
  - rst overrides every other input, including mid-operation.
- States:
  - IDLE: start with op 000–011 and flush=0 -> latch operands, go to CALC, counter=0.
  - CALC: one radix-2 step per cycle for exactly WIDTH cycles; counter increments; at counter==WIDTH-1 -> FIX.
  - FIX: sign correction, write hi/lo at end of cycle -> IDLE.
- Timing, with start sampled in cycle 0:
  - busy=1 in cycles 1..33.
  - done=1 in cycle 34 only; hi/lo hold the new values from cycle 34.
- Multiply:
  - Shift-add on magnitudes with a 2*WIDTH product register.
  - Signed ops use |a|,|b|; in FIX the product is negated if a[31]^b[31].
  - hi=product[63:32], lo=product[31:0].
- Divide:
  - Restoring division on magnitudes: quotient -> lo, remainder -> hi.
  - Signed ops: quotient negated if signs differ; remainder takes the sign of the dividend.
  - 0x80000000 / 0xFFFFFFFF gives lo=0x80000000, hi=0 (natural wrap, no trap).
  - Divide by zero still takes the full latency and gives lo=0xFFFFFFFF, hi=dividend (unsigned magnitude, sign-fixed for DIV).
- MTHI/MTLO:
  - Accepted only in IDLE.
  - hi (or lo) written at the end of the start cycle.
  - No busy, no done.
- Stall:
  - stall = busy & (start | rd_hilo), combinational.
  - Any start while busy is ignored; the pipeline re-presents it after busy falls.
  - MFHI/MFLO in the done cycle is not stalled and reads the new values.
- Flush:
  - In CALC or FIX: return to IDLE next cycle, hi/lo unchanged, no done, busy=0 from the next cycle.
  - flush together with start in IDLE: start ignored (applies to MTHI/MTLO too).
- No-op codes 110/111: ignored, no state change.

Test Plan:
- MULT a=0xFFFFFFFD, b=7 -> busy cycles 1..33, done cycle 34, hi=0xFFFFFFFF, lo=0xFFFFFFEB.
- MULTU a=b=0xFFFFFFFF -> hi=0xFFFFFFFE, lo=0x00000001.
- DIV a=0xFFFFFFF9 (-7), b=2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF.
- DIV a=0x80000000, b=0xFFFFFFFF -> lo=0x80000000, hi=0.
- DIVU a=0x64, b=0 -> lo=0xFFFFFFFF, hi=0x64 after 34 cycles.
- MTLO 0x1234 in IDLE -> lo=0x1234 next cycle.
- Start DIVU 100/3, then MTHI 0xAA at cycle 5 -> stall=1 at cycle 5, MTHI ignored.
- Same DIVU, flush at cycle 10 -> busy=0 at cycle 11, no done, hi/lo unchanged.
- rst pulsed at cycle 20 of a MULT -> hi=lo=0, busy=0 next cycle.
- rd_hilo=1 in cycles 5 and 34 of a MULT -> stall=1 in cycle 5, stall=0 in cycle 34.

Source files
------------

// File: rtl/muldiv_seq_if.sv
// Handshake/result bundle between the EX stage and the multiply/divide sequencer.
//   master (pipeline side): drives start, op, a, b, rd_hilo, flush
//   slave  (muldiv_seq)   : drives busy, stall, done, hi, lo
interface muldiv_seq_if #(
    parameter int WIDTH = 32
);
    logic             start;
    logic [2:0]       op;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             rd_hilo;
    logic             flush;
    logic             busy;
    logic             stall;
    logic             done;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;

    modport master (
        output start, op, a, b, rd_hilo, flush,
        input  busy, stall, done, hi, lo
    );

    modport slave (
        input  start, op, a, b, rd_hilo, flush,
        output busy, stall, done, hi, lo
    );
endinterface

// File: rtl/muldiv_seq.sv
// Iterative MULT/MULTU/DIV/DIVU sequencer owning the HI/LO registers.
// A mult/div started in cycle 0 is busy in cycles 1..33 and pulses done in
// cycle 34 with the new HI/LO. MTHI/MTLO complete in the start cycle.
//
// Ports:
//   clk  - system clock, all state on the rising edge
//   rst  - synchronous active-high reset
//   bus  - muldiv_seq_if.slave: start/op/a/b/rd_hilo/flush in,
//          busy/stall/done/hi/lo out
//
// State | meaning
// IDLE  | waiting for a request; MTHI/MTLO served here
// CALC  | one radix-2 multiply/divide step per cycle, WIDTH cycles
// FIX   | sign correction, HI/LO written at end of cycle
module muldiv_seq #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 6
) (
    input logic          clk,
    input logic          rst,
    muldiv_seq_if.slave  bus
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        FIX  = 2'd2
    } state_t;

    state_t state_q, state_d;

    logic [CNT_W-1:0]   cnt_q;
    logic [2*WIDTH-1:0] acc_q;      // mult: {partial, multiplier}; div: {remainder, quotient}
    logic [WIDTH-1:0]   opb_q;      // mult: |multiplicand|; div: |divisor|
    logic               is_div_q;
    logic               neg_res_q;  // negate product / quotient
    logic               neg_rem_q;  // negate remainder (dividend sign)
    logic               div_zero_q;
    logic [WIDTH-1:0]   hi_q, lo_q;
    logic               done_q;

    logic               accept;
    logic               start_md;
    logic               wr_mthi, wr_mtlo;
    logic               is_signed;
    logic               a_neg, b_neg;
    logic [WIDTH-1:0]   a_mag, b_mag;
    logic               last_step;

    logic [WIDTH:0]     mul_sum;
    logic [2*WIDTH-1:0] mul_next;
    logic [WIDTH:0]     div_shift;
    logic               div_ge;
    logic [WIDTH-1:0]   div_rem;
    logic [2*WIDTH-1:0] div_next;

    logic [2*WIDTH-1:0] prod_fix;
    logic [WIDTH-1:0]   quo, rem;
    logic [WIDTH-1:0]   fix_hi, fix_lo;

    // Request decode: only IDLE accepts anything, and flush squashes the request.
    assign accept    = bus.start && !bus.flush && (state_q == IDLE);
    assign start_md  = accept && !bus.op[2];
    assign wr_mthi   = accept && (bus.op == 3'b100);
    assign wr_mtlo   = accept && (bus.op == 3'b101);

    // op[0] set means unsigned (MULTU/DIVU).
    assign is_signed = !bus.op[0];
    assign a_neg     = is_signed && bus.a[WIDTH-1];
    assign b_neg     = is_signed && bus.b[WIDTH-1];
    assign a_mag     = a_neg ? (-bus.a) : bus.a;
    assign b_mag     = b_neg ? (-bus.b) : bus.b;

    assign last_step = (cnt_q == CNT_W'(WIDTH - 1));

    // Shift-add step: add multiplicand into the upper half when the current
    // multiplier LSB is set, then shift the whole register right (carry in).
    assign mul_sum  = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, opb_q} : '0);
    assign mul_next = {mul_sum, acc_q[WIDTH-1:1]};

    // Restoring step: shift next dividend bit into the remainder and subtract
    // the divisor if it fits. A zero divisor always "fits", which yields an
    // all-ones quotient and leaves the dividend in the remainder.
    assign div_shift = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]};
    assign div_ge    = (div_shift >= {1'b0, opb_q});
    assign div_rem   = div_ge ? (div_shift[WIDTH-1:0] - opb_q) : div_shift[WIDTH-1:0];
    assign div_next  = {div_rem, acc_q[WIDTH-2:0], div_ge};

    // Sign correction. Divide by zero keeps the all-ones quotient as is.
    assign prod_fix = neg_res_q ? (-acc_q) : acc_q;
    assign quo      = acc_q[WIDTH-1:0];
    assign rem      = acc_q[2*WIDTH-1:WIDTH];
    assign fix_lo   = is_div_q ? ((neg_res_q && !div_zero_q) ? (-quo) : quo)
                               : prod_fix[WIDTH-1:0];
    assign fix_hi   = is_div_q ? (neg_rem_q ? (-rem) : rem)
                               : prod_fix[2*WIDTH-1:WIDTH];

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (start_md) begin
                    state_d = CALC;
                end
            end
            CALC: begin
                if (bus.flush) begin
                    state_d = IDLE;
                end else if (last_step) begin
                    state_d = FIX;
                end
            end
            FIX: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q      <= '0;
            acc_q      <= '0;
            opb_q      <= '0;
            is_div_q   <= 1'b0;
            neg_res_q  <= 1'b0;
            neg_rem_q  <= 1'b0;
            div_zero_q <= 1'b0;
            hi_q       <= '0;
            lo_q       <= '0;
            done_q     <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (start_md) begin
                        cnt_q      <= '0;
                        is_div_q   <= bus.op[1];
                        neg_res_q  <= a_neg ^ b_neg;
                        neg_rem_q  <= a_neg;
                        div_zero_q <= (bus.b == '0);
                        if (bus.op[1]) begin
                            acc_q <= {{WIDTH{1'b0}}, a_mag};
                            opb_q <= b_mag;
                        end else begin
                            acc_q <= {{WIDTH{1'b0}}, b_mag};
                            opb_q <= a_mag;
                        end
                    end
                    if (wr_mthi) begin
                        hi_q <= bus.a;
                    end
                    if (wr_mtlo) begin
                        lo_q <= bus.a;
                    end
                end
                CALC: begin
                    if (!bus.flush) begin
                        acc_q <= is_div_q ? div_next : mul_next;
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                FIX: begin
                    if (!bus.flush) begin
                        hi_q   <= fix_hi;
                        lo_q   <= fix_lo;
                        done_q <= 1'b1;
                    end
                end
                default: begin
                    cnt_q <= '0;
                end
            endcase
        end
    end

    assign bus.busy  = (state_q != IDLE);
    assign bus.stall = bus.busy && (bus.start || bus.rd_hilo);
    assign bus.done  = done_q;
    assign bus.hi    = hi_q;
    assign bus.lo    = lo_q;

endmodule
